// File: rtl/cmos_capture_pkg.sv
// cmos_capture_pkg: shared FSM state, RGB565 word type and default geometry for the DVP capture path.
package cmos_capture_pkg;
  typedef enum logic [1:0] {IDLE, SKIP, WAIT_VS, CAPTURE} state_t;
  typedef logic [15:0] rgb565_t;
  localparam int DEF_SKIP_FRAMES = 10;
  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES = 480;
  function automatic rgb565_t pack565(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction
endpackage

// File: rtl/cmos_capture_if.sv
// cmos_capture_if: sensor inputs, write-FIFO port and status of the capture front end.
// CMOS_CAPTURE_SIZE_CHECK_EN adds the size_err status line.
interface cmos_capture_if;
  import cmos_capture_pkg::*;
  logic cfg_done;
  logic cam_vsync;
  logic cam_href;
  logic [7:0] cam_data;
  logic wr_full;
  logic wr_en;
  rgb565_t wr_data;
  logic frame_start;
  logic cap_done;
  logic overflow;
`ifdef CMOS_CAPTURE_SIZE_CHECK_EN
  logic size_err;
  modport master(output cfg_done, cam_vsync, cam_href, cam_data, wr_full,
                 input wr_en, wr_data, frame_start, cap_done, overflow, size_err);
  modport slave(input cfg_done, cam_vsync, cam_href, cam_data, wr_full,
                output wr_en, wr_data, frame_start, cap_done, overflow, size_err);
`else
  modport master(output cfg_done, cam_vsync, cam_href, cam_data, wr_full,
                 input wr_en, wr_data, frame_start, cap_done, overflow);
  modport slave(input cfg_done, cam_vsync, cam_href, cam_data, wr_full,
                output wr_en, wr_data, frame_start, cap_done, overflow);
`endif
endinterface

// File: rtl/cmos_capture_byte_pack.sv
// cap_byte_pack: pairs DVP bytes (high first) into RGB565 words; a dangling odd byte at line end is dropped.
module cap_byte_pack import cmos_capture_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_href,
  input  logic [7:0] i_data,
  output rgb565_t    o_word,
  output logic       o_valid
);
  logic r_phase;
  logic [7:0] r_hi;
  rgb565_t r_word;
  logic r_valid;
  logic w_take;
  assign w_take = i_href & ~i_clr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_phase <= 1'b0;
      r_hi <= '0;
      r_word <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_take & r_phase;
      r_phase <= w_take ? ~r_phase : 1'b0;
      if (w_take && !r_phase) r_hi <= i_data;
      if (w_take && r_phase) r_word <= pack565(r_hi, i_data);
    end
  assign o_word = r_word;
  assign o_valid = r_valid;
endmodule

// File: rtl/cmos_capture.sv
// cmos_capture: DVP sensor capture into the SDRAM write FIFO, skipping settling frames after configuration.
// CMOS_CAPTURE_SIZE_CHECK_EN adds a per-frame geometry check reported on size_err.
module cmos_capture import cmos_capture_pkg::*; #(
  parameter int SKIP_FRAMES = DEF_SKIP_FRAMES,
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES = DEF_V_LINES
) (
  input logic clk,
  input logic rst,
  cmos_capture_if.slave bus
);
  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  if (SKIP_FRAMES < 0 || H_PIXELS < 1 || V_LINES < 1) begin : g_bad_cfg
    $error("cmos_capture: invalid SKIP_FRAMES/H_PIXELS/V_LINES");
  end
  logic r_vs, r_vs_d, r_href;
  logic [7:0] r_data;
  state_t r_state;
  logic [SW-1:0] r_skip;
  logic r_wr_en, r_fs, r_cd, r_ovf;
  rgb565_t r_wr_data;
  rgb565_t w_word;
  logic w_valid, w_vs_rise, w_clr, w_accept;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_vs <= 1'b0;
      r_vs_d <= 1'b0;
      r_href <= 1'b0;
      r_data <= '0;
    end else begin
      r_vs <= bus.cam_vsync;
      r_vs_d <= r_vs;
      r_href <= bus.cam_href;
      r_data <= bus.cam_data;
    end
  assign w_vs_rise = r_vs & ~r_vs_d;
  assign w_clr = ~bus.cfg_done | (r_state != CAPTURE);
  assign w_accept = bus.cfg_done & (r_state == CAPTURE) & w_valid;
  cap_byte_pack u_pack (
    .clk(clk),
    .rst(rst),
    .i_clr(w_clr),
    .i_href(r_href),
    .i_data(r_data),
    .o_word(w_word),
    .o_valid(w_valid)
  );
`ifdef CMOS_CAPTURE_SIZE_CHECK_EN
  localparam int PW = $clog2(H_PIXELS + 1);
  localparam int LW = $clog2(V_LINES + 1);
  logic [PW-1:0] r_pix, w_pix_next;
  logic [LW-1:0] r_line;
  logic r_href_d, r_line_bad, r_size_err, w_href_fall, w_size_bad;
  // the last word of a line and its href fall land on the same edge, so count it in
  assign w_pix_next = r_pix + PW'(w_valid);
  assign w_href_fall = r_href_d & ~r_href;
  assign w_size_bad = r_line_bad | (r_line != LW'(V_LINES));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_href_d <= 1'b0;
      r_pix <= '0;
      r_line <= '0;
      r_line_bad <= 1'b0;
    end else begin
      r_href_d <= r_href;
      r_pix <= w_href_fall ? '0 : w_pix_next;
      if (w_vs_rise) begin
        r_line <= '0;
        r_line_bad <= 1'b0;
      end else if (w_href_fall) begin
        r_line <= r_line + 1'b1;
        if (w_pix_next != PW'(H_PIXELS)) r_line_bad <= 1'b1;
      end
    end
  assign bus.size_err = r_size_err;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_skip <= '0;
      r_wr_en <= 1'b0;
      r_wr_data <= '0;
      r_fs <= 1'b0;
      r_cd <= 1'b0;
      r_ovf <= 1'b0;
`ifdef CMOS_CAPTURE_SIZE_CHECK_EN
      r_size_err <= 1'b0;
`endif
    end else begin
      r_fs <= 1'b0;
      r_cd <= 1'b0;
`ifdef CMOS_CAPTURE_SIZE_CHECK_EN
      r_size_err <= 1'b0;
`endif
      r_wr_en <= w_accept & ~bus.wr_full;
      if (w_accept) r_wr_data <= w_word;
      if (w_accept && bus.wr_full) r_ovf <= 1'b1;
      if (!bus.cfg_done) begin
        r_state <= IDLE;
        r_skip <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
            r_skip <= '0;
          end
          SKIP: if (w_vs_rise) begin
            if (r_skip == SW'(SKIP_FRAMES - 1)) r_state <= WAIT_VS;
            r_skip <= r_skip + 1'b1;
          end
          WAIT_VS: if (w_vs_rise) begin
            r_state <= CAPTURE;
            r_fs <= 1'b1;
          end
          CAPTURE: if (w_vs_rise) begin
            r_fs <= 1'b1;
            r_cd <= 1'b1;
`ifdef CMOS_CAPTURE_SIZE_CHECK_EN
            r_size_err <= w_size_bad;
`endif
          end
        endcase
      end
    end
  assign bus.wr_en = r_wr_en;
  assign bus.wr_data = r_wr_data;
  assign bus.frame_start = r_fs;
  assign bus.cap_done = r_cd;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_cmos_capture.sv
// tb_cmos_capture: randomized DVP frames against a frame-level reference model of the capture path.
module tb_cmos_capture;
  import cmos_capture_pkg::*;
  localparam int SK = 2;
  localparam int H = 8;
  localparam int V = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cmos_capture_if bus();
  cmos_capture #(.SKIP_FRAMES(SK), .H_PIXELS(H), .V_LINES(V)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int total = 0, bad = 0, cyc = 0;
  bit full_sched[0:32767];
  logic [15:0] q[$];
  logic [7:0] pat[$];
  logic [7:0] hi;
  bit cap = 0, cfg = 0, exp_ovf = 0, fbad = 0, pend_bad = 0, noise = 0, ph = 0;
  int k = 0, nl = 0, wcl = 0, drops = 0, exp_fs = 0, exp_cd = 0, cnt_fs = 0, cnt_cd = 0, n_wr = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    cnt_fs += int'(bus.frame_start);
    cnt_cd += int'(bus.cap_done);
    if (bus.wr_en) begin
      n_wr++;
      if (q.size() == 0) chk("wr_extra", bus.wr_en, 0);
      else chk("wr_data", bus.wr_data, q.pop_front());
    end
    if (bus.cap_done) chk("cd_with_fs", bus.frame_start, 1);
`ifdef CMOS_CAPTURE_SIZE_CHECK_EN
    if (bus.cap_done) chk("size_err", bus.size_err, pend_bad);
    else if (bus.size_err) chk("size_spur", bus.size_err, 0);
`endif
  end
  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    bus.cam_vsync = vs;
    bus.cam_href = hr;
    bus.cam_data = d;
    bus.cfg_done = cfg;
    bus.wr_full = full_sched[cyc + 1];
    @(posedge clk);
    #1;
  endtask
  // a word's fate is decided by wr_full two edges after its second byte is sampled
  task automatic byte_in(input logic [7:0] d);
    int e;
    bit drop;
    e = cyc + 1;
    if (!ph) begin
      hi = d;
      full_sched[e + 2] = noise && ($urandom_range(0, 1) == 1);
    end else begin
      drop = cap && (drops > 0 || (noise && $urandom_range(0, 5) == 0));
      if (cap && drops > 0) drops--;
      full_sched[e + 2] = drop;
      wcl++;
      if (cap) begin
        if (drop) exp_ovf = 1;
        else q.push_back({hi, d});
      end
    end
    ph = !ph;
    step(0, 1, d);
  endtask
  task automatic line_end();
    ph = 0;
    repeat (4) step(0, 0, 0);
    nl++;
    if (wcl != H) fbad = 1;
    wcl = 0;
  endtask
  task automatic line(input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = (pat.size() != 0) ? pat.pop_front() : 8'($urandom);
      byte_in(d);
    end
    line_end();
  endtask
  task automatic vsync();
    if (cfg) begin
      k++;
      if (k > SK) exp_fs++;
      if (k > SK + 1) exp_cd++;
      cap = (k > SK);
    end
    pend_bad = fbad || (nl != V);
    fbad = 0;
    nl = 0;
    repeat (2) step(1, 0, 0);
    repeat (4) step(0, 0, 0);
  endtask
  task automatic frame(input int lines);
    vsync();
    repeat (lines) line(2 * H);
  endtask
  initial begin
    bus.cfg_done = 0;
    bus.cam_vsync = 0;
    bus.cam_href = 0;
    bus.cam_data = 0;
    bus.wr_full = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_cd", bus.cap_done, 0);
    chk("rst_ovf", bus.overflow, 0);
    @(posedge clk);
    #1 rst = 0;
    cfg = 1;
    repeat (3) step(0, 0, 0);
    repeat (2) frame(V);
    chk("skip_fs", cnt_fs, 0);
    chk("skip_wr", n_wr, 0);
    repeat (2) frame(V);
    chk("t1_fs", cnt_fs, exp_fs);
    chk("t1_cd", cnt_cd, exp_cd);
    vsync();
    chk("t1_wr_cnt", n_wr, 2 * H * V);
    chk("t1_cd2", cnt_cd, exp_cd);
    byte_in(8'hF8);
    byte_in(8'h1F);
    step(0, 0, 0);
    @(negedge clk);
    chk("lat_early", bus.wr_en, 0);
    step(0, 0, 0);
    @(negedge clk);
    chk("lat_wr_en", bus.wr_en, 1);
    chk("lat_data", bus.wr_data, 16'hF81F);
    line_end();
    pat = '{8'h12, 8'h34, 8'h56};
    line(3);
    pat = '{8'hAB, 8'hCD};
    line(2 * H);
    repeat (V - 3) line(2 * H);
    vsync();
    line(2 * H);
    drops = 5;
    line(2 * H);
    repeat (V - 2) line(2 * H);
    chk("ovf_set", bus.overflow, exp_ovf);
    frame(V);
    chk("ovf_sticky", bus.overflow, exp_ovf);
    vsync();
    repeat (2) line(2 * H);
    cfg = 0;
    cap = 0;
    k = 0;
    step(0, 0, 0);
    repeat (V - 2) line(2 * H);
    frame(V);
    chk("abort_cd", cnt_cd, exp_cd);
    cfg = 1;
    repeat (3) step(0, 0, 0);
    repeat (2) frame(V);
    chk("reskip_fs", cnt_fs, exp_fs);
    frame(V);
    chk("recap_fs", cnt_fs, exp_fs);
    chk("ovf_keep", bus.overflow, exp_ovf);
    noise = 1;
    for (int f = 0; f < 8; f++) begin
      int sel, nlines;
      sel = (f == 0) ? 0 : (f == 1) ? 2 : $urandom_range(0, 3);
      nlines = (sel == 0) ? V - 1 : V;
      vsync();
      for (int l = 0; l < nlines; l++)
        line((sel == 1 && l == 2) ? $urandom_range(2 * H - 2, 2 * H + 2) : 2 * H);
    end
    vsync();
    repeat (6) step(0, 0, 0);
    chk("end_q_empty", q.size(), 0);
    chk("end_fs", cnt_fs, exp_fs);
    chk("end_cd", cnt_cd, exp_cd);
    chk("end_ovf", bus.overflow, exp_ovf);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
